// File: rtl/glitch_sequencer_if.sv
// rtl/glitch_sequencer_if.sv - shared serial register bus bundle for the glitch sequencer
interface glitch_sequencer_if;
    logic [7:0]  reg_cmd;
    logic [15:0] reg_bytecount;
    logic [7:0]  reg_data_in;
    logic [7:0]  reg_data_out;
    logic        reg_read;
    logic        reg_write;

    modport master (
        output reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        input  reg_data_out
    );

    modport slave (
        input  reg_cmd, reg_bytecount, reg_data_in, reg_read, reg_write,
        output reg_data_out
    );
endinterface

// File: rtl/glitch_sequencer.sv
// rtl/glitch_sequencer.sv - armed trigger scheduler playing back up to four (delay, width) pulse slots
module glitch_sequencer #(
    parameter int NUM_SLOTS = 4,
    parameter int CMD_BASE  = 40
) (
    input  logic               timerclk,
    input  logic               reset,
    input  logic               trigger_in,
    glitch_sequencer_if.slave  bus,
    output logic               glitch_out,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DELAY = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

    localparam logic [7:0] CMD_CTRL  = 8'(CMD_BASE + 0);
    localparam logic [7:0] CMD_SEL   = 8'(CMD_BASE + 1);
    localparam logic [7:0] CMD_DLY   = 8'(CMD_BASE + 2);
    localparam logic [7:0] CMD_WID   = 8'(CMD_BASE + 3);
    localparam logic [7:0] CMD_CNT   = 8'(CMD_BASE + 4);
    localparam logic [7:0] CMD_STS   = 8'(CMD_BASE + 5);
    localparam logic [2:0] MAX_COUNT = 3'(NUM_SLOTS);

    // Slot storage is always four deep so the 2-bit selectors index it cleanly;
    // entries at or above NUM_SLOTS are never written and read back as 0.
    logic [31:0] delay_r [4];
    logic [15:0] width_r [4];
    logic [2:0]  count_r;
    logic [1:0]  slot_sel;
    logic        auto_rearm;
    logic        err;
    logic        done_sticky;
    logic [7:0]  pulse_cnt;
    logic        trig_prev;

    state_t      state, state_nx;
    logic [31:0] counter, counter_nx;
    logic [1:0]  cur_slot, slot_nx;
    logic        glitch_nx;
    logic        done_nx;
    logic        pulse_fire;

    logic [15:0] bc;
    logic        wr_ctrl, arm_req, abort_req, clear_req;
    logic        cfg_write, cfg_drop, sel_ok;
    logic        trig_edge;
    logic [2:0]  active_cnt;
    logic        last_slot;
    logic [1:0]  next_slot;
    logic [15:0] cur_width;
    logic [31:0] pulse_load;
    logic [31:0] sel_delay;
    logic [15:0] sel_width;
    logic [7:0]  rd_data;

    assign bc        = bus.reg_bytecount;
    assign wr_ctrl   = bus.reg_write && (bus.reg_cmd == CMD_CTRL) && (bc == 16'd0);
    assign arm_req   = wr_ctrl && bus.reg_data_in[0];
    assign abort_req = wr_ctrl && bus.reg_data_in[1];
    assign clear_req = wr_ctrl && bus.reg_data_in[3];
    assign cfg_write = bus.reg_write && ((bus.reg_cmd == CMD_SEL) || (bus.reg_cmd == CMD_DLY) ||
                                         (bus.reg_cmd == CMD_WID) || (bus.reg_cmd == CMD_CNT));
    assign cfg_drop  = cfg_write && busy;
    assign sel_ok    = ({1'b0, slot_sel} < MAX_COUNT);

    // Edge detector runs in every state so a level held across re-arm never retriggers.
    assign trig_edge = trigger_in && !trig_prev;

    assign active_cnt = (count_r == 3'd0)      ? 3'd1 :
                        (count_r > MAX_COUNT)  ? MAX_COUNT : count_r;
    assign last_slot  = (({1'b0, cur_slot} + 3'd1) >= active_cnt);
    assign next_slot  = cur_slot + 2'd1;
    assign cur_width  = width_r[cur_slot];
    assign pulse_load = (cur_width == 16'd0) ? 32'd0 : {16'd0, cur_width - 16'd1};

    assign busy      = (state == ST_DELAY) || (state == ST_PULSE);
    assign sel_delay = delay_r[slot_sel];
    assign sel_width = width_r[slot_sel];

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge timerclk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            counter    <= 32'd0;
            cur_slot   <= 2'd0;
            glitch_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            counter    <= counter_nx;
            cur_slot   <= slot_nx;
            glitch_out <= glitch_nx;
            done       <= done_nx;
        end
    end

    // Next-state logic: abort overrides everything, the delay counter only decrements when nonzero.
    always_comb begin
        state_nx   = state;
        counter_nx = counter;
        slot_nx    = cur_slot;
        glitch_nx  = glitch_out;
        done_nx    = 1'b0;
        pulse_fire = 1'b0;
        if (abort_req) begin
            state_nx  = ST_IDLE;
            glitch_nx = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm_req) state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_edge) begin
                        state_nx   = ST_DELAY;
                        counter_nx = delay_r[0];
                        slot_nx    = 2'd0;
                    end
                end
                ST_DELAY: begin
                    if (counter == 32'd0) begin
                        state_nx   = ST_PULSE;
                        glitch_nx  = 1'b1;
                        counter_nx = pulse_load;
                    end else begin
                        counter_nx = counter - 32'd1;
                    end
                end
                ST_PULSE: begin
                    if (counter == 32'd0) begin
                        glitch_nx  = 1'b0;
                        pulse_fire = 1'b1;
                        if (last_slot) begin
                            done_nx  = 1'b1;
                            state_nx = auto_rearm ? ST_ARMED : ST_IDLE;
                        end else begin
                            slot_nx    = next_slot;
                            state_nx   = ST_DELAY;
                            counter_nx = delay_r[next_slot];
                        end
                    end else begin
                        counter_nx = counter - 32'd1;
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Configuration registers, sticky status and the trigger history bit.
    always_ff @(posedge timerclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                delay_r[i] <= 32'd0;
                width_r[i] <= 16'd0;
            end
            count_r     <= 3'd1;
            slot_sel    <= 2'd0;
            auto_rearm  <= 1'b0;
            err         <= 1'b0;
            done_sticky <= 1'b0;
            pulse_cnt   <= 8'd0;
            trig_prev   <= 1'b0;
        end else begin
            trig_prev <= trigger_in;
            if (wr_ctrl) auto_rearm <= bus.reg_data_in[2];
            if (cfg_write && !busy) begin
                case (bus.reg_cmd)
                    CMD_SEL: if (bc == 16'd0) slot_sel <= bus.reg_data_in[1:0];
                    CMD_DLY: if (bc < 16'd4 && sel_ok)
                        delay_r[slot_sel][{bc[1:0], 3'b000} +: 8] <= bus.reg_data_in;
                    CMD_WID: if (bc < 16'd2 && sel_ok)
                        width_r[slot_sel][{bc[0], 3'b000} +: 8] <= bus.reg_data_in;
                    CMD_CNT: if (bc == 16'd0) count_r <= bus.reg_data_in[2:0];
                    default: ;
                endcase
            end
            err         <= (err && !clear_req) || cfg_drop;
            done_sticky <= (done_sticky && !clear_req) || done_nx;
            pulse_cnt   <= (clear_req ? 8'd0 : pulse_cnt) + {7'd0, pulse_fire};
        end
    end

    // Combinational read mux; unknown commands and out-of-range bytes read as 0.
    always_comb begin
        rd_data = 8'h00;
        if (bus.reg_read) begin
            case (bus.reg_cmd)
                CMD_SEL: if (bc == 16'd0) rd_data = {6'd0, slot_sel};
                CMD_DLY: if (bc < 16'd4) rd_data = sel_delay[{bc[1:0], 3'b000} +: 8];
                CMD_WID: if (bc < 16'd2) rd_data = sel_width[{bc[0], 3'b000} +: 8];
                CMD_CNT: if (bc == 16'd0) rd_data = {5'd0, count_r};
                CMD_STS: begin
                    if (bc == 16'd0)      rd_data = {cur_slot, err, done_sticky, 2'b00, state};
                    else if (bc == 16'd1) rd_data = pulse_cnt;
                end
                default: ;
            endcase
        end
    end

    assign bus.reg_data_out = rd_data;

endmodule
